mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single external byte-wide memory port between the multicycle CPU core (requester 0) and a host/loader port (requester 1). Each requester uses a req/gnt handshake. Winners are chosen round-robin, and the block sequences one memory access per grant. It sits between the core/loader and the top-level memory pins. Read data is returned after a fixed, parameterised memory latency.

Parameters:
WIDTH, 8, address and data width in bits.
RDLAT, 1, number of cycles from the mem_rd strobe cycle to valid mem_rdata. Legal range is at least 1.

Ports:
clk  in  1  clock, all logic on the rising edge
rst_n  in  1  synchronous reset, active low
req  in  2  per-requester access request, index 0 = core, 1 = host
we  in  2  per-requester write enable (1 = write, 0 = read)
adr0, adr1  in  WIDTH  per-requester address
wdata0, wdata1  in  WIDTH  per-requester write data
gnt  out  2  one-cycle completion pulse to the owning requester
rdata  out  WIDTH  read data register shared by both requesters
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_adr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active low on rst_n.
- Reset values: state = IDLE. gnt, mem_rd, mem_wr, busy are 0. mem_adr, mem_wdata, rdata are 0. Round-robin pointer last = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, DONE. The state encoding comes from the package.
- IDLE:
  - If req is nonzero, pick a winner.
  - With one request, that requester wins. With both, the requester != last wins.
  - Latch owner, we[owner], adr and wdata into mem_adr, mem_wdata and the op register.
  - Go to ACCESS. Otherwise stay in IDLE.
- ACCESS:
  - Exactly one cycle.
  - mem_wr = 1 if the op is a write, else mem_rd = 1. mem_adr and mem_wdata are held.
  - Write: go to DONE. Read: load the counter with RDLAT and go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - On the cycle where the counter equals 1, capture mem_rdata into rdata and go to DONE.
  - The counter width is clog2(RDLAT+1).
- DONE:
  - gnt[owner] = 1 for one cycle.
  - last <= owner. Go to IDLE.
  - rdata holds its value until the next read capture; writes do not change it.
- Latency, counted from the cycle req is sampled in IDLE:
  - Write: gnt in cycle +2.
  - Read: gnt in cycle +2+RDLAT.
  - Next arbitration happens in the cycle after DONE.
- Requester rules:
  - Hold req, we, adr and wdata stable until gnt.
  - A req still high in the cycle after gnt is a new transaction.
- Back-to-back: when both requesters hold req continuously, grants alternate 0,1,0,1 with no starvation.
- Request withdrawn before gnt: this is a protocol violation. The transaction already latched completes and gnt still pulses.
- Inputs outside IDLE: req changes are ignored. The other requester waits.
- Reset mid-operation: the transaction aborts with no gnt. Strobes are 0 from the next cycle and the FSM is in IDLE.
- Strobe exclusivity: mem_rd and mem_wr are never both 1. Neither is high outside ACCESS.

Optional Feature:
Macro MEM_ARB_LOCK_EN.
- Enabled:
  - Adds input lock (2 bits).
  - If lock[owner] = 1 at DONE, the owner keeps the bus. In following IDLE cycles only that requester's req is eligible. last is not updated.
  - The lock is released when lock[owner] is sampled 0 in IDLE. Normal round-robin then resumes in that same cycle.
- Disabled: the port is absent and behaviour is pure round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - the arbstate enum {IDLE, ACCESS, WAIT, DONE}, 2 bits;
  - constants REQ_CORE = 0 and REQ_HOST = 1.
- One sub-module, arb_rr2: a two-way round-robin picker. Inputs are req[1:0], last and (optional) the lock mask. Outputs are valid and winner.
- The FSM, latency counter and data registers stay in mem_arbiter.

Test Plan:
- Reset, then req=01, we=01, adr0=8'h10, wdata0=8'hA5: mem_wr=1 with mem_adr=10, mem_wdata=A5 in cycle +1; gnt=01 in cycle +2; rdata stays 00.
- RDLAT=1, req=10, we=00, adr1=8'h3C, mem returns 8'h5A in the WAIT cycle: mem_rd pulses in cycle +1; gnt=10 and rdata=5A in cycle +3.
- req=11 held continuously, all reads: grant sequence 01,10,01,10; busy drops for exactly one IDLE cycle between grants.
- rst_n=0 asserted during WAIT of a read: no gnt pulse; mem_rd and mem_wr are 0; busy=0 next cycle; the first post-reset tie goes to requester 0.
- RDLAT=3 read of adr 8'hFF with mem_rdata=8'h81 in the third WAIT cycle: gnt appears 5 cycles after request sampling and rdata=81.
- MEM_ARB_LOCK_EN defined, lock=01, req=11: requester 0 is granted three times in a row. Lock is dropped in IDLE and requester 1 is granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arbstate_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic [1:0] mask_i,
    output logic       valid_o,
    output logic       winner_o
);

    logic [1:0] elig;

    assign elig     = req_i & mask_i;
    assign valid_o  = |elig;
    assign winner_o = (&elig) ? ~last_i : elig[REQ_HOST];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core (0) and host (1) onto one byte-wide memory port, one access per grant.
// Optional bus locking is compiled in with MEM_ARB_LOCK_EN.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates and latches the winner's access
// ACCESS | one-cycle mem_rd or mem_wr strobe
// WAIT   | read latency countdown, captures mem_rdata when the count reaches 1
// DONE   | one-cycle gnt pulse to the owner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RDLAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic [1:0]       lock_i,
`endif
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [WIDTH-1:0] adr0_i,
    input  logic [WIDTH-1:0] adr1_i,
    input  logic [WIDTH-1:0] wdata0_i,
    input  logic [WIDTH-1:0] wdata1_i,
    output logic [1:0]       gnt_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic [WIDTH-1:0] mem_adr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             busy_o
);

    localparam int CW = $clog2(RDLAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RDLAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arbstate_e        state_q, state_d;
    logic             owner_q, last_q, op_we_q;
    logic [WIDTH-1:0] adr_q, wdata_q, rdata_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       pick_mask;
    logic             pick_valid, pick_winner;

`ifdef MEM_ARB_LOCK_EN
    logic locked_q;
    logic lock_hold;

    // A held lock restricts eligibility to the current owner only.
    assign lock_hold = locked_q && lock_i[owner_q];
    assign pick_mask = lock_hold ? ((owner_q == REQ_CORE) ? 2'b01 : 2'b10) : 2'b11;
`else
    assign pick_mask = 2'b11;
`endif

    arb_rr2 u_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .mask_i   (pick_mask),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  state_d = op_we_q ? DONE : WAIT;
            WAIT:    if (cnt_q == CNT_ONE) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o    = 2'b00;
        mem_rd_o = 1'b0;
        mem_wr_o = 1'b0;
        busy_o   = (state_q != IDLE);
        if (state_q == ACCESS) begin
            mem_rd_o = ~op_we_q;
            mem_wr_o = op_we_q;
        end
        if (state_q == DONE) gnt_o[owner_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            owner_q <= REQ_CORE;
            last_q  <= REQ_HOST;
            op_we_q <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_winner;
                        op_we_q <= we_i[pick_winner];
                        adr_q   <= (pick_winner == REQ_HOST) ? adr1_i : adr0_i;
                        wdata_q <= (pick_winner == REQ_HOST) ? wdata1_i : wdata0_i;
                    end
`ifdef MEM_ARB_LOCK_EN
                    if (!lock_hold) locked_q <= 1'b0;
`endif
                end
                ACCESS: if (!op_we_q) cnt_q <= CNT_LOAD;
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) rdata_q <= mem_rdata_i;
                end
                DONE: begin
`ifdef MEM_ARB_LOCK_EN
                    // While locked the pointer is frozen so release resumes fair order.
                    locked_q <= lock_i[owner_q];
                    if (!lock_i[owner_q]) last_q <= owner_q;
`else
                    last_q <= owner_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign mem_adr_o   = adr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RDLAT=1 instance plus an RDLAT=3 instance.
module tb_mem_arbiter;

    typedef struct {
        logic [1:0] gnt;
        logic [7:0] rdata;
        int         cyc;
    } gnt_exp_t;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] adr;
        logic [7:0] wdata;
        int         cyc;
    } strb_exp_t;

    logic       clk, rst_n;
    logic [1:0] req, req3, we, lock;
    logic [7:0] adr0, adr1, wdata0, wdata1;

    logic [1:0] gnt, gnt3;
    logic [7:0] rdata, rdata3, mem_adr, mem_adr3, mem_wdata, mem_wdata3;
    logic [7:0] mem_rdata, mem_rdata3;
    logic       mem_rd, mem_wr, busy, mem_rd3, mem_wr3, busy3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    gnt_exp_t  q_gnt[$],  q_gnt3[$];
    strb_exp_t q_strb[$], q_strb3[$];

    mem_arbiter #(.WIDTH(8), .RDLAT(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
`ifdef MEM_ARB_LOCK_EN
        .lock_i(lock),
`endif
        .req_i(req), .we_i(we), .adr0_i(adr0), .adr1_i(adr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1), .gnt_o(gnt), .rdata_o(rdata),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_adr_o(mem_adr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_arbiter #(.WIDTH(8), .RDLAT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
`ifdef MEM_ARB_LOCK_EN
        .lock_i(2'b00),
`endif
        .req_i(req3), .we_i(we), .adr0_i(adr0), .adr1_i(adr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1), .gnt_o(gnt3), .rdata_o(rdata3),
        .mem_rd_o(mem_rd3), .mem_wr_o(mem_wr3), .mem_adr_o(mem_adr3),
        .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3), .busy_o(busy3)
    );

    function automatic logic [7:0] mem_model(input logic [7:0] a);
        if (a == 8'h3C)      return 8'h5A;
        else if (a == 8'hFF) return 8'h81;
        else                 return a ^ 8'hC3;
    endfunction

    assign mem_rdata  = mem_model(mem_adr);
    assign mem_rdata3 = mem_model(mem_adr3);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin : mon1
        gnt_exp_t  ge;
        strb_exp_t se;
        if (gnt !== 2'b00) begin
            if (q_gnt.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'h0);
            else begin
                ge = q_gnt.pop_front();
                chk("gnt", 32'(gnt), 32'(ge.gnt));
                chk("gnt_rdata", 32'(rdata), 32'(ge.rdata));
                chk("gnt_cycle", cyc, ge.cyc);
            end
        end
        if (mem_rd || mem_wr) begin
            chk("strobe_excl", 32'(mem_rd & mem_wr), 32'h0);
            if (q_strb.size() == 0) chk("unexpected_strobe", 32'({mem_rd, mem_wr}), 32'h0);
            else begin
                se = q_strb.pop_front();
                chk("strobe_rd", 32'(mem_rd), 32'(se.rd));
                chk("strobe_wr", 32'(mem_wr), 32'(se.wr));
                chk("strobe_adr", 32'(mem_adr), 32'(se.adr));
                chk("strobe_wdata", 32'(mem_wdata), 32'(se.wdata));
                chk("strobe_cycle", cyc, se.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon3
        gnt_exp_t  ge;
        strb_exp_t se;
        if (gnt3 !== 2'b00) begin
            if (q_gnt3.size() == 0) chk("unexpected_gnt3", 32'(gnt3), 32'h0);
            else begin
                ge = q_gnt3.pop_front();
                chk("gnt3", 32'(gnt3), 32'(ge.gnt));
                chk("gnt3_rdata", 32'(rdata3), 32'(ge.rdata));
                chk("gnt3_cycle", cyc, ge.cyc);
            end
        end
        if (mem_rd3 || mem_wr3) begin
            if (q_strb3.size() == 0) chk("unexpected_strobe3", 32'({mem_rd3, mem_wr3}), 32'h0);
            else begin
                se = q_strb3.pop_front();
                chk("strobe3_rdwr", 32'({mem_rd3, mem_wr3}), 32'({se.rd, se.wr}));
                chk("strobe3_adr", 32'(mem_adr3), 32'(se.adr));
                chk("strobe3_cycle", cyc, se.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_g(input logic [1:0] g, input logic [7:0] rd, input int c);
        gnt_exp_t e;
        e.gnt = g; e.rdata = rd; e.cyc = c;
        q_gnt.push_back(e);
    endtask

    task automatic push_s(input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input int c);
        strb_exp_t e;
        e.rd = r; e.wr = w; e.adr = a; e.wdata = d; e.cyc = c;
        q_strb.push_back(e);
    endtask

    initial begin : stim
        int c;
        gnt_exp_t  g3;
        strb_exp_t s3;
        rst_n = 1'b0; req = 2'b00; req3 = 2'b00; we = 2'b00; lock = 2'b00;
        adr0 = 8'h00; adr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_adr", 32'(mem_adr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy3", 32'(busy3), 32'h0);

        // core write
        c = cyc;
        req = 2'b01; we = 2'b01; adr0 = 8'h10; wdata0 = 8'hA5; wdata1 = 8'h77;
        push_s(1'b0, 1'b1, 8'h10, 8'hA5, c + 1);
        push_g(2'b01, 8'h00, c + 2);
        tick(2);
        req = 2'b00;
        tick(1);

        // host read, RDLAT=1
        c = cyc;
        req = 2'b10; we = 2'b00; adr1 = 8'h3C;
        push_s(1'b1, 1'b0, 8'h3C, 8'h77, c + 1);
        push_g(2'b10, 8'h5A, c + 3);
        tick(3);
        req = 2'b00;
        tick(1);

        // both requesting continuously: alternating grants
        c = cyc;
        req = 2'b11; adr0 = 8'h20; adr1 = 8'h21;
        for (int k = 0; k < 4; k++) begin
            push_s(1'b1, 1'b0, (k % 2 == 0) ? 8'h20 : 8'h21,
                   (k % 2 == 0) ? 8'hA5 : 8'h77, c + 1 + 4 * k);
            push_g((k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 8'hE3 : 8'hE2, c + 3 + 4 * k);
        end
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            chk("rr_busy", 32'(busy), 32'((k % 4) != 0));
        end
        req = 2'b00;
        tick(1);

        // reset during WAIT aborts without gnt
        c = cyc;
        req = 2'b01; adr0 = 8'h44;
        push_s(1'b1, 1'b0, 8'h44, 8'hA5, c + 1);
        tick(2);
        rst_n = 1'b0; req = 2'b00;
        tick(1);
        chk("abort_strobes", 32'({mem_rd, mem_wr}), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_rdata", 32'(rdata), 32'h0);
        tick(1);
        c = cyc;
        rst_n = 1'b1; req = 2'b11; adr0 = 8'h50; adr1 = 8'h51;
        push_s(1'b1, 1'b0, 8'h50, 8'hA5, c + 1);
        push_g(2'b01, 8'h93, c + 3);
        push_s(1'b1, 1'b0, 8'h51, 8'h77, c + 5);
        push_g(2'b10, 8'h92, c + 7);
        tick(7);
        req = 2'b00;
        tick(1);

        // RDLAT=3 read on the second instance
        c = cyc;
        req3 = 2'b01; adr0 = 8'hFF;
        s3.rd = 1'b1; s3.wr = 1'b0; s3.adr = 8'hFF; s3.wdata = 8'hA5; s3.cyc = c + 1;
        q_strb3.push_back(s3);
        g3.gnt = 2'b01; g3.rdata = 8'h81; g3.cyc = c + 5;
        q_gnt3.push_back(g3);
        tick(5);
        req3 = 2'b00;
        tick(1);

`ifdef MEM_ARB_LOCK_EN
        // core holds the lock for three grants, then host gets the bus
        c = cyc;
        lock = 2'b01; req = 2'b11; adr0 = 8'h60; adr1 = 8'h61;
        for (int k = 0; k < 3; k++) begin
            push_s(1'b1, 1'b0, 8'h60, 8'hA5, c + 1 + 4 * k);
            push_g(2'b01, 8'hA3, c + 3 + 4 * k);
        end
        push_s(1'b1, 1'b0, 8'h61, 8'h77, c + 13);
        push_g(2'b10, 8'hA2, c + 15);
        tick(11);
        req = 2'b10;
        tick(1);
        lock = 2'b00;
        tick(3);
        req = 2'b00;
        tick(1);
`endif

        tick(4);
        while (q_gnt.size() != 0) begin
            g3 = q_gnt.pop_front();
            chk("missing_gnt", 32'h0, 32'(g3.gnt));
        end
        while (q_gnt3.size() != 0) begin
            g3 = q_gnt3.pop_front();
            chk("missing_gnt3", 32'h0, 32'(g3.gnt));
        end
        while (q_strb.size() != 0) begin
            s3 = q_strb.pop_front();
            chk("missing_strobe", 32'h0, 32'(s3.adr) | 32'h100);
        end
        while (q_strb3.size() != 0) begin
            s3 = q_strb3.pop_front();
            chk("missing_strobe3", 32'h0, 32'(s3.adr) | 32'h100);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
